register_write_back: RTL

- Write-back end of the register-file interface: owns the 8x16 architectural register file and commits results from the final pipeline stage.
- Serves the read stage's paired read request: a 6-bit address yields a 32-bit read word containing two registers.
- Keeps a busy scoreboard so decode stalls on RAW/WAW hazards, and clears squashed entries on a flush.

---
 rtl/register_write_back_pkg.sv | 40 ++++
 rtl/register_write_back_reg_scoreboard.sv | 75 +++++++
 rtl/register_write_back.sv | 80 ++++++++
 3 files changed

// File: rtl/register_write_back_pkg.sv
// ----------------------------------------------------------------------------
// register_write_back_pkg
// Shared constants and types for the write-back register-file slice.
//   - Register file geometry (8 x 16).
//   - Field positions of the paired read address {srcA, srcB}.
//   - Layout of the 32-bit paired read word (srcA in the upper half).
//   - One-hot helper used by the scoreboard to build per-register masks.
// ----------------------------------------------------------------------------
package register_write_back_pkg;

  localparam int NREG   = 8;    // architectural registers (3-bit address)
  localparam int REG_AW = 3;
  localparam int DW     = 16;
  localparam int RD_W   = 2 * DW;

  // Paired read address fields: {srcA[5:3], srcB[2:0]}
  localparam int SRC_A_HI = 5;
  localparam int SRC_A_LO = 3;
  localparam int SRC_B_HI = 2;
  localparam int SRC_B_LO = 0;

  // Paired read word layout: R[srcA] in [31:16], R[srcB] in [15:0]
  localparam int RD_A_HI = 31;
  localparam int RD_A_LO = 16;
  localparam int RD_B_HI = 15;
  localparam int RD_B_LO = 0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DW-1:0]     reg_data_t;
  typedef logic [NREG-1:0]   reg_mask_t;

  // One-hot mask of addr, or all-zero when en is low.
  function automatic reg_mask_t reg_onehot(input logic en, input reg_addr_t addr);
    reg_mask_t m;
    m = '0;
    if (en) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/register_write_back_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// Busy-bit scoreboard for the architectural registers.
//   clk, resetn      : clock, asynchronous active-low reset
//   wb_valid/wb_addr : commit clears busy[wb_addr]
//   iss_valid/addr   : issue sets busy[iss_addr] (dropped when flush is high)
//   squash_mask/flush: flush clears every masked busy bit
//   src_a, src_b     : read-stage sources, hazard-checked with iss_addr
//   busy             : current scoreboard
//   hazard           : decode must stall
//   sb_err           : sticky protocol-violation flag
// ----------------------------------------------------------------------------
module reg_scoreboard
  import register_write_back_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  input  logic [NREG-1:0]   squash_mask,
  input  logic              flush,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic [NREG-1:0]   busy,
  output logic              hazard,
  output logic              sb_err
);

  reg_mask_t busy_reg;
  reg_mask_t busy_next;
  logic      sb_err_reg;
  logic      sb_err_next;

  reg_mask_t wb_clr;    // register being committed this cycle
  reg_mask_t iss_set;   // register being claimed by a surviving issue
  reg_mask_t busy_eff;  // busy bits still blocking after this cycle's commit

  assign wb_clr   = reg_onehot(wb_valid, wb_addr);
  assign iss_set  = reg_onehot(iss_valid && !flush, iss_addr);
  assign busy_eff = busy_reg & ~wb_clr;

  // Clear by commit, then by flush, then set by issue: a same-cycle set
  // wins over either clear of the same register.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] = iss_set[gi] |
                             (busy_reg[gi] & ~wb_clr[gi] & ~(flush & squash_mask[gi]));
    end
  endgenerate

  // A register being committed this cycle is not a hazard: the read path
  // bypasses wb_data to the dependent instruction.
  assign hazard = busy_eff[src_a] | busy_eff[src_b] | busy_eff[iss_addr];

  assign sb_err_next = sb_err_reg |
                       (iss_valid & hazard) |
                       (wb_valid & ~busy_reg[wb_addr]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_reg   <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      sb_err_reg <= sb_err_next;
    end
  end

  assign busy   = busy_reg;
  assign sb_err = sb_err_reg;

endmodule

// File: rtl/register_write_back.sv
// ----------------------------------------------------------------------------
// register_write_back
// Write-back end of the register-file interface: 8x16 architectural
// register file, paired combinational read with write-through bypass, and
// the busy scoreboard used by decode for RAW/WAW stalls.
//   clk, resetn      : clock, asynchronous active-low reset
//   wb_valid/addr/data : commit from the final pipeline stage
//   iss_valid/iss_addr : instruction issue claiming a destination
//   squash_mask, flush : squash pending producers on a flush
//   reg_read_addr    : {srcA, srcB} from the read stage
//   reg_Read_Data    : {R[srcA], R[srcB]}
//   hazard, busy, sb_err : scoreboard status
// ----------------------------------------------------------------------------
module register_write_back
  import register_write_back_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DW-1:0]       wb_data,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_addr,
  input  logic [NREG-1:0]     squash_mask,
  input  logic                flush,
  input  logic [2*REG_AW-1:0] reg_read_addr,
  output logic [RD_W-1:0]     reg_Read_Data,
  output logic                hazard,
  output logic [NREG-1:0]     busy,
  output logic                sb_err
);

  // The array clears asynchronously, so it lives in flops rather than RAM.
  reg_data_t regs_reg [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (wb_valid) begin
      regs_reg[wb_addr] <= wb_data;
    end
  end

  reg_addr_t src_a;
  reg_addr_t src_b;

  assign src_a = reg_read_addr[SRC_A_HI:SRC_A_LO];
  assign src_b = reg_read_addr[SRC_B_HI:SRC_B_LO];

  // Each half reads independently, so srcA == srcB with a bypass yields
  // wb_data in both halves.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      localparam int LO = (gi == 1) ? RD_A_LO : RD_B_LO;
      localparam int HI = (gi == 1) ? RD_A_HI : RD_B_HI;
      reg_addr_t field;
      assign field = (gi == 1) ? src_a : src_b;
      assign reg_Read_Data[HI:LO] = (wb_valid && (wb_addr == field)) ? wb_data
                                                                     : regs_reg[field];
    end
  endgenerate

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .resetn      (resetn),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .squash_mask (squash_mask),
    .flush       (flush),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .hazard      (hazard),
    .sb_err      (sb_err)
  );

endmodule
